mult_seq_arb: RTL and testbench

//  - Shares one WIDTH-bit multiplier between NREQ requesters; each request is a product of NOPS operands.
//  - Round-robin arbiter picks a requester and latches its operand vector.
//  - Sequencer then folds the product one operand per clock; result returns on a valid/ready port tagged with requester id.
//  - Sits in front of the registered multi-input product datapath, time-multiplexing it instead of replicating it.

---
 rtl/mult_seq_pkg.sv | 11 +
 rtl/mult_seq_arb_rr_arbiter.sv | 24 ++
 rtl/mult_seq_arb.sv | 84 ++++++++
 tb/tb_mult_seq_arb.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: FSM state type and width/slice helpers for the shared sequential multiplier
package mult_seq_pkg;
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    localparam int MIN_W = 1;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : MIN_W;
    endfunction
    function automatic int op_base(input int r, input int k, input int nops, input int width);
        return (r * nops + k) * width;
    endfunction
endpackage

// File: rtl/mult_seq_arb_rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick, searching upward from ptr with wrap
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);
    logic found;
    always_comb begin
        idx = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (en && !found && req[(int'(ptr) + i) % NREQ]) begin
                found = 1'b1;
                idx = IDW'((int'(ptr) + i) % NREQ);
            end
        end
        gnt = found ? (NREQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/mult_seq_arb.sv
// mult_seq_arb: round-robin shared multiplier folding NOPS operands per request, one per clock.
// MULT_SEQ_EARLY_EXIT_EN: finish as soon as the running product reaches zero.
module mult_seq_arb
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int NOPS  = 5,
    parameter int NREQ  = 2,
    parameter int IDW   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*NOPS*WIDTH-1:0] ops,
    output logic [NREQ-1:0]            gnt,
    output logic                       busy,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [IDW-1:0]             out_id,
    input  logic                       out_ready
);
    localparam int IXW = idx_w(NOPS);
`ifdef MULT_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    state_t state;
    logic [WIDTH-1:0] op_reg [NOPS];
    logic [WIDTH-1:0] acc, prod, op0;
    logic [IXW-1:0] idx;
    logic [IDW-1:0] id, ptr, win;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req(req),
        .ptr(ptr),
        .en(state == IDLE && !rst),
        .gnt(gnt),
        .idx(win)
    );

    assign op0 = ops[op_base(int'(win), 0, NOPS, WIDTH) +: WIDTH];
    assign prod = acc * op_reg[idx];
    assign out_data = acc;
    assign out_id = id;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy <= 1'b0;
            out_valid <= 1'b0;
            acc <= '0;
            idx <= '0;
            id <= '0;
            ptr <= '0;
        end else begin
            case (state)
                IDLE: if (|gnt) begin
                    for (int k = 0; k < NOPS; k++)
                        op_reg[k] <= ops[op_base(int'(win), k, NOPS, WIDTH) +: WIDTH];
                    acc <= op0;
                    idx <= IXW'(1);
                    id <= win;
                    ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
                    busy <= 1'b1;
                    out_valid <= (NOPS == 1) || (EARLY && op0 == '0);
                    state <= ((NOPS == 1) || (EARLY && op0 == '0)) ? DONE : MUL;
                end
                MUL: begin
                    acc <= prod;
                    idx <= idx + 1'b1;
                    out_valid <= (idx == IXW'(NOPS - 1)) || (EARLY && prod == '0);
                    state <= ((idx == IXW'(NOPS - 1)) || (EARLY && prod == '0)) ? DONE : MUL;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_seq_arb.sv
// tb_mult_seq_arb: directed checks of arbitration, folding, latency, backpressure and reset
module tb_mult_seq_arb;
    logic clk = 1'b0;
    logic rst;
    logic [1:0] req8, gnt8, req1, gnt1;
    logic [47:0] ops8;
    logic [9:0] ops1;
    logic busy8, ov8, ready8, busy1, ov1, ready1;
    logic [7:0] data8;
    logic [0:0] data1, id8, id1;
    int passed = 0, failed = 0, total = 0;

    always #5 clk = ~clk;

    mult_seq_arb #(.WIDTH(8), .NOPS(3), .NREQ(2), .IDW(1)) d8 (
        .clk(clk), .rst(rst), .req(req8), .ops(ops8), .gnt(gnt8), .busy(busy8),
        .out_valid(ov8), .out_data(data8), .out_id(id8), .out_ready(ready8)
    );
    mult_seq_arb #(.WIDTH(1), .NOPS(5), .NREQ(2), .IDW(1)) d1 (
        .clk(clk), .rst(rst), .req(req1), .ops(ops1), .gnt(gnt1), .busy(busy1),
        .out_valid(ov1), .out_data(data1), .out_id(id1), .out_ready(ready1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait8(input bit drop, output int n);
        n = 0;
        do begin
            step();
            if (drop) req8 = 2'b00;
            n++;
        end while (!ov8 && n < 20);
    endtask

    task automatic wait1(output int n);
        n = 0;
        do begin
            step();
            req1 = 2'b00;
            n++;
        end while (!ov1 && n < 20);
    endtask

    initial begin
        int n, gc;
        int gt [4];
        logic [1:0] gv [4];
        logic ok;
        rst = 1'b1;
        req8 = 2'b11;
        req1 = 2'b00;
        ready8 = 1'b0;
        ready1 = 1'b1;
        ops8 = '0;
        ops1 = '0;
        step();
        step();
        chk("rst_gnt", gnt8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_valid", ov8, 0);
        chk("rst_data", data8, 0);
        chk("rst_id", id8, 0);
        req8 = 2'b00;
        rst = 1'b0;
        step();
        chk("idle_busy", busy8, 0);

        // single request: 2*3*4
        ops8[23:0] = {8'd4, 8'd3, 8'd2};
        req8 = 2'b01;
        #1;
        chk("t1_gnt", gnt8, 2'b01);
        wait8(1'b1, n);
        chk("t1_lat", n, 3);
        chk("t1_data", data8, 24);
        chk("t1_id", id8, 0);
        chk("t1_busy", busy8, 1);
        ready8 = 1'b1;
        step();
        chk("t1_hs_valid", ov8, 0);
        chk("t1_hs_busy", busy8, 0);

        // overflow on requester 1: 16*16*3 mod 256
        ops8[47:24] = {8'd3, 8'd16, 8'd16};
        req8 = 2'b10;
        #1;
        chk("t2_gnt", gnt8, 2'b10);
        wait8(1'b1, n);
`ifdef MULT_SEQ_EARLY_EXIT_EN
        chk("t2_lat", n, 2);
`else
        chk("t2_lat", n, 3);
`endif
        chk("t2_data", data8, 0);
        chk("t2_id", id8, 1);
        step();
        chk("t2_hs_valid", ov8, 0);

        // round robin with both requesting
        ops8[47:24] = {8'd5, 8'd1, 8'd1};
        req8 = 2'b11;
        #1;
        gc = 0;
        for (int i = 0; i < 16; i++) begin
            if (gnt8 != 2'b00 && gc < 4) begin
                gv[gc] = gnt8;
                gt[gc] = i;
                gc++;
            end
            if (ov8) chk("rr_data", data8, id8 ? 5 : 24);
            step();
        end
        req8 = 2'b00;
        chk("rr_count", gc, 4);
        for (int j = 0; j < 4; j++) begin
            chk("rr_who", gv[j], (j % 2) ? 2'b10 : 2'b01);
            chk("rr_when", gt[j], 4 * j);
        end

        // backpressure with req held
        ready8 = 1'b0;
        req8 = 2'b11;
        #1;
        chk("bp_gnt", gnt8, 2'b01);
        wait8(1'b0, n);
        chk("bp_lat", n, 3);
        for (int i = 0; i < 10; i++) begin
            ok = ov8 && data8 == 8'd24 && id8 == 1'b0 && gnt8 == 2'b00 && busy8;
            chk("bp_hold", ok, 1);
            step();
        end
        ready8 = 1'b1;
        step();
        chk("bp_hs_valid", ov8, 0);
        chk("bp_next_gnt", gnt8, 2'b10);
        req8 = 2'b00;
        step();
        chk("bp_idle", busy8, 0);

        // reset one cycle after grant
        req8 = 2'b11;
        #1;
        chk("rm_gnt", gnt8, 2'b10);
        step();
        req8 = 2'b00;
        chk("rm_busy_mul", busy8, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rm_busy", busy8, 0);
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ok = ok && !ov8 && !busy8;
            step();
        end
        chk("rm_quiet", ok, 1);
        req8 = 2'b11;
        #1;
        chk("rm_ptr0", gnt8, 2'b01);
        wait8(1'b1, n);
        chk("rm_data", data8, 24);
        step();

        // WIDTH=1, NOPS=5: zero at operand 1
        ops1 = {5'b11111, 5'b11101};
        req1 = 2'b01;
        #1;
        chk("w1_gnt", gnt1, 2'b01);
        wait1(n);
`ifdef MULT_SEQ_EARLY_EXIT_EN
        chk("w1_lat", n, 2);
`else
        chk("w1_lat", n, 5);
`endif
        chk("w1_data", data1, 0);
        chk("w1_id", id1, 0);
        step();
        req1 = 2'b10;
        #1;
        chk("w1b_gnt", gnt1, 2'b10);
        wait1(n);
        chk("w1b_lat", n, 5);
        chk("w1b_data", data1, 1);
        chk("w1b_id", id1, 1);
        step();
        chk("w1b_hs", ov1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
